// File: rtl/arith_pkg.sv
// Shared arithmetic package for the bit-serial byte adder / subtractor pair.
// Holds the serial-FSM state encoding and the default operand width.
package arith_pkg;

    // Default operand width, shared with the byte subtractor.
    localparam int DEFAULT_WIDTH = 8;

    // Serial FSM states. Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_adder.sv
// Combinational single-bit full adder; the serial adder's only arithmetic cell.
// Ports:
//   bit_a, bit_b   - operand bits
//   bit_carry_in   - carry into this bit
//   bit_sum        - sum bit
//   bit_carry_out  - carry out of this bit
module bit_adder (
    input  logic bit_a,
    input  logic bit_b,
    input  logic bit_carry_in,
    output logic bit_sum,
    output logic bit_carry_out
);

    logic half;

    assign half          = bit_a ^ bit_b;
    assign bit_sum       = half ^ bit_carry_in;
    assign bit_carry_out = (bit_a & bit_b) | (bit_carry_in & half);

endmodule

// File: rtl/byte_serial_adder.sv
// Bit-serial byte adder. Operands are captured on an accepted start, summed
// LSB-first through one full-adder cell over adder_size cycles, and the result
// (sum, carry out, signed overflow) is published with a one-cycle done pulse.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   start           - request strobe, sampled only in IDLE
//   byte_a, byte_b  - addends, captured on accepted start
//   byte_carry_in   - carry into bit 0, captured on accepted start
//   byte_sum        - registered sum, held until the next completion
//   byte_carry_out  - carry out of the MSB
//   byte_overflow   - two's-complement overflow
//   busy            - high in ADD and DONE
//   done            - one-cycle result-valid pulse
module byte_serial_adder
    import arith_pkg::*;
#(
    parameter int adder_size = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [adder_size-1:0] byte_a,
    input  logic [adder_size-1:0] byte_b,
    input  logic                  byte_carry_in,
    output logic [adder_size-1:0] byte_sum,
    output logic                  byte_carry_out,
    output logic                  byte_overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(adder_size);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(adder_size - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(adder_size - 2);

    state_t                state_q, state_d;
    logic [adder_size-1:0] a_sh, b_sh, sum_sh;
    logic [CNT_W-1:0]      cnt;
    logic                  c, c_msb_in;
    logic                  fa_sum, fa_cout;

    bit_adder u_bit_adder (
        .bit_a         (a_sh[0]),
        .bit_b         (b_sh[0]),
        .bit_carry_in  (c),
        .bit_sum       (fa_sum),
        .bit_carry_out (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = ADD;
            ADD: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh           <= '0;
            b_sh           <= '0;
            sum_sh         <= '0;
            cnt            <= '0;
            c              <= 1'b0;
            c_msb_in       <= 1'b0;
            byte_sum       <= '0;
            byte_carry_out <= 1'b0;
            byte_overflow  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh <= byte_a;
                        b_sh <= byte_b;
                        c    <= byte_carry_in;
                        cnt  <= '0;
                    end
                end
                ADD: begin
                    sum_sh <= {fa_sum, sum_sh[adder_size-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c      <= fa_cout;
                    cnt    <= cnt + 1'b1;
                    // Carry out of bit adder_size-2 is the carry into the MSB.
                    if (cnt == CNT_PRE) c_msb_in <= fa_cout;
                    // Publish on the edge that enters DONE; the final sum bit
                    // is taken straight from the cell, not from sum_sh.
                    if (cnt == CNT_LAST) begin
                        byte_sum       <= {fa_sum, sum_sh[adder_size-1:1]};
                        byte_carry_out <= fa_cout;
                        byte_overflow  <= c_msb_in ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
